// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and derived totals.
package vga_timing_pkg;

  localparam int unsigned CntW = 10;

  localparam int unsigned HDisplayDef = 640;
  localparam int unsigned HFrontDef   = 16;
  localparam int unsigned HSyncDef    = 96;
  localparam int unsigned HBackDef    = 48;

  localparam int unsigned VDisplayDef = 480;
  localparam int unsigned VFrontDef   = 10;
  localparam int unsigned VSyncDef    = 2;
  localparam int unsigned VBackDef    = 33;

  localparam int unsigned HTotalDef = HDisplayDef + HFrontDef + HSyncDef + HBackDef;
  localparam int unsigned VTotalDef = VDisplayDef + VFrontDef + VSyncDef + VBackDef;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..Total-1 while en is high, wrap flags the last position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Total = HTotalDef
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic [CntW-1:0] count,
  output logic            wrap
);

  localparam logic [CntW-1:0] Last = CntW'(Total - 1);

  logic [CntW-1:0] count_q;

  // Reset parks at the last position so the first enabled edge lands on 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= Last;
    end else if (en) begin
      count_q <= wrap ? '0 : count_q + 1'b1;
    end
  end

  assign wrap  = en && (count_q == Last);
  assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Optional frame counter enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = HDisplayDef,
  parameter int unsigned H_FRONT   = HFrontDef,
  parameter int unsigned H_SYNC    = HSyncDef,
  parameter int unsigned H_BACK    = HBackDef,
  parameter int unsigned V_DISPLAY = VDisplayDef,
  parameter int unsigned V_FRONT   = VFrontDef,
  parameter int unsigned V_SYNC    = VSyncDef,
  parameter int unsigned V_BACK    = VBackDef,
  parameter bit          SYNC_NEG  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  output logic [CntW-1:0] hpos,
  output logic [CntW-1:0] vpos,
  output logic            hsync,
  output logic            vsync,
  output logic            display_on,
  output logic            line_start,
  output logic            frame_start,
  output logic [7:0]      frame_count
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (HTotal > 1024) begin : g_h_total_err
    $error("vga_timing: H_TOTAL exceeds 1024");
  end
  if (VTotal > 1024) begin : g_v_total_err
    $error("vga_timing: V_TOTAL exceeds 1024");
  end

  localparam logic [CntW-1:0] HDisp      = CntW'(H_DISPLAY);
  localparam logic [CntW-1:0] VDisp      = CntW'(V_DISPLAY);
  localparam logic [CntW-1:0] HSyncStart = CntW'(H_DISPLAY + H_FRONT);
  localparam logic [CntW-1:0] HSyncEnd   = CntW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CntW-1:0] VSyncStart = CntW'(V_DISPLAY + V_FRONT);
  localparam logic [CntW-1:0] VSyncEnd   = CntW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic h_wrap;
  logic v_wrap;
  logic hsync_act;
  logic vsync_act;

  vga_axis_counter #(
    .Total(HTotal)
  ) u_h_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (ce),
    .count(hpos),
    .wrap (h_wrap)
  );

  // h_wrap already includes ce, so the vertical axis steps once per line.
  vga_axis_counter #(
    .Total(VTotal)
  ) u_v_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (h_wrap),
    .count(vpos),
    .wrap (v_wrap)
  );

  assign hsync_act   = (hpos >= HSyncStart) && (hpos <= HSyncEnd);
  assign vsync_act   = (vpos >= VSyncStart) && (vpos <= VSyncEnd);
  assign hsync       = hsync_act ^ SYNC_NEG;
  assign vsync       = vsync_act ^ SYNC_NEG;
  assign display_on  = (hpos < HDisp) && (vpos < VDisp);
  assign line_start  = (hpos == '0);
  assign frame_start = (hpos == '0) && (vpos == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_q;

  // Starts at 8'hFF so the first frame after reset reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= 8'hFF;
    end else if (h_wrap && v_wrap) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign frame_count = frame_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default timing (both sync polarities) and a tiny timing for frames.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default-timing DUTs share reset/ce.
  logic       reset, ce;
  logic [9:0] hpos0, vpos0, hpos1, vpos1;
  logic       hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
  logic [7:0] fc0, fc1;

  // Small-timing DUT: H 8/2/3/2 = 15, V 4/1/2/1 = 8, frame = 120 clocks.
  logic       reset2, ce2;
  logic [9:0] hpos2, vpos2;
  logic       hs2, vs2, de2, ls2, fs2;
  logic [7:0] fc2;

  vga_timing u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .hpos(hpos0), .vpos(vpos0), .hsync(hs0), .vsync(vs0),
    .display_on(de0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing #(.SYNC_NEG(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .hpos(hpos1), .vpos(vpos1), .hsync(hs1), .vsync(vs1),
    .display_on(de1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  vga_timing #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut2 (
    .clk(clk), .reset(reset2), .ce(ce2), .hpos(hpos2), .vpos(vpos2), .hsync(hs2), .vsync(vs2),
    .display_on(de2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_fc(input int f);
`ifdef VGA_TIMING_FRAME_CNT_EN
    return 8'(f);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    int hs_low, vs_low, fs_cnt, vs_first_v, vs_first_h;
    bit vs_seen;

    reset = 1'b1; ce = 1'b1; reset2 = 1'b1; ce2 = 1'b0;
    tick(2);
    check("rst_hpos", hpos0, 799);
    check("rst_vpos", vpos0, 524);
    check("rst_display_on", de0, 0);
    check("rst_hsync", hs0, 1);
    check("rst_vsync", vs0, 1);
    check("rst_line_start", ls0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_hsync_pos", hs1, 0);
    check("rst_frame_count", fc2, 32'(exp_fc(255)));

    // Release: first ce edge lands on (0,0).
    reset = 1'b0;
    tick(1);
    check("first_hpos", hpos0, 0);
    check("first_vpos", vpos0, 0);
    check("first_frame_start", fs0, 1);
    check("first_display_on", de0, 1);
    check("first_line_start", ls0, 1);

    tick(639);
    check("de_639", de0, 1);
    tick(1);
    check("de_640", de0, 0);
    tick(15);
    check("hpos_655", hpos0, 655);
    check("hs_655", hs0, 1);
    check("hs_pos_655", hs1, 0);
    tick(1);
    check("hs_656", hs0, 0);
    check("hs_pos_656", hs1, 1);
    tick(95);
    check("hs_751", hs0, 0);
    tick(1);
    check("hs_752", hs0, 1);
    tick(47);
    check("hpos_799", hpos0, 799);
    check("vpos_line0", vpos0, 0);
    tick(1);
    check("wrap_hpos", hpos0, 0);
    check("wrap_vpos", vpos0, 1);
    check("wrap_line_start", ls0, 1);
    check("wrap_frame_start", fs0, 0);

    // ce toggling: line_start held for two clocks at hpos=0, one step per two clocks.
    ce = 1'b0;
    tick(1);
    check("hold_hpos", hpos0, 0);
    check("hold_line_start", ls0, 1);
    ce = 1'b1;
    tick(1);
    check("tog_hpos1", hpos0, 1);
    check("tog_line_start", ls0, 0);
    ce = 1'b0;
    tick(1);
    check("tog_hold1", hpos0, 1);
    ce = 1'b1;
    tick(1);
    check("tog_hpos2", hpos0, 2);

    // Mid-line reset returns straight to the park position.
    tick(298);
    check("pre_rst_hpos", hpos0, 300);
    reset = 1'b1;
    tick(1);
    check("mid_rst_hpos", hpos0, 799);
    check("mid_rst_vpos", vpos0, 524);
    check("mid_rst_de", de0, 0);
    check("mid_rst_hsync", hs0, 1);
    check("mid_rst_vsync", vs0, 1);
    ce = 1'b0;
    tick(1);
    check("rst_no_ce_hpos", hpos0, 799);

    // Small-timing DUT: 256 frames of frame-level checks.
    reset2 = 1'b0; ce2 = 1'b1;
    tick(1);
    hs_low = 0; vs_low = 0; fs_cnt = 0; vs_seen = 1'b0; vs_first_v = 0; vs_first_h = 0;
    for (int f = 0; f <= 256; f++) begin
      check("frame_start_at_00", fs2, 1);
      check("frame_count", fc2, 32'(exp_fc(f)));
      if (f == 256) break;
      for (int k = 0; k < 120; k++) begin
        if (f == 0) begin
          if (!hs2) hs_low++;
          if (!vs2) begin
            vs_low++;
            if (!vs_seen) begin
              vs_seen = 1'b1;
              vs_first_v = int'(vpos2);
              vs_first_h = int'(hpos2);
            end
          end
          if (fs2) fs_cnt++;
        end
        tick(1);
      end
      if (f == 0) begin
        check("frame_start_per_frame", fs_cnt, 1);
        check("hsync_low_clocks", hs_low, 24);
        check("vsync_low_clocks", vs_low, 30);
        check("vsync_first_vpos", vs_first_v, 5);
        check("vsync_first_hpos", vs_first_h, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_DISPLAY, default 480, visible lines.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_NEG, default 1, where 1 means hsync/vsync are active-low.
REQ-010 SHALL have port clk, input, 1 bit, the single clock.
REQ-011 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-012 SHALL have port ce, input, 1 bit, pixel enable (counters advance only when high).
REQ-013 SHALL have port hpos, output, 10 bits, current pixel column.
REQ-014 SHALL have port vpos, output, 10 bits, current line.
REQ-015 SHALL have port hsync, output, 1 bit, horizontal sync.
REQ-016 SHALL have port vsync, output, 1 bit, vertical sync.
REQ-017 SHALL have port display_on, output, 1 bit, high inside the visible area.
REQ-018 SHALL have port line_start, output, 1 bit, high while hpos==0.
REQ-019 SHALL have port frame_start, output, 1 bit, high while hpos==0 and vpos==0.
REQ-020 SHALL have port frame_count, output, 8 bits, frame index.

Function
REQ-021 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-022 SHALL increment hpos by 1 on each clk edge with ce=1, wrapping H_TOTAL-1 -> 0; with ce=0 all registered state holds.
REQ-023 SHALL increment vpos only on the ce edge where hpos wraps, wrapping V_TOTAL-1 -> 0 on the same edge that hpos wraps.
REQ-024 SHALL drive display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY), aligned with hpos/vpos in the same cycle and with no extra latency.
REQ-025 SHALL assert hsync (active level) for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751], with the same alignment as REQ-024.
REQ-026 SHALL assert vsync (active level) for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491], for entire lines.
REQ-027 SHALL output sync active level 0 when SYNC_NEG=1 and 1 when SYNC_NEG=0.
REQ-028 SHALL keep line_start and frame_start high for every clock the counters hold at those positions (ce=0 does not shorten or repeat-count them).
REQ-029 SHALL reject, via an elaboration-time error, any H_TOTAL or V_TOTAL greater than 1024.

Reset
REQ-030 SHALL, while reset=1, hold hpos=H_TOTAL-1 (799) and vpos=V_TOTAL-1 (524), regardless of ce.
REQ-031 SHALL therefore present display_on=0, hsync/vsync inactive, line_start=0, and frame_start=0 during reset.
REQ-032 SHALL make the first ce=1 edge after reset deassertion produce hpos=0, vpos=0, and frame_start=1.
REQ-033 SHALL, when reset is asserted mid-frame, return to REQ-030 values on the next edge without completing the current line.

Configuration
REQ-034 SHALL gate the frame counter with macro VGA_TIMING_FRAME_CNT_EN.
REQ-035 SHALL, with the macro defined, reset frame_count to 8'hFF and increment it on each ce edge entering (0,0), wrapping 255 -> 0, so the first frame after reset reads 0.
REQ-036 SHALL, with the macro undefined, keep the port present, tie frame_count to 0, and instantiate no counter flops.

Structure
REQ-037 SHALL place the default timing constants (640/16/96/48, 480/10/33/2) and the derived totals in shared package vga_timing_pkg.
REQ-038 SHALL implement each axis with one sub-module vga_axis_counter (inputs: count enable and reset; outputs: count and wrap pulse), instantiated once for horizontal and once for vertical.

Verification
REQ-039 SHALL cover: reset released, ce=1 -> next cycle hpos=0, vpos=0, frame_start=1, display_on=1.
REQ-040 SHALL cover: ce=1 continuously for 420000 cycles -> frame_start period is exactly 420000 cycles, hsync low for exactly 96 cycles starting at hpos=656, and vsync low for exactly 1600 cycles starting at vpos=490, hpos=0.
REQ-041 SHALL cover: ce toggling 1,0,1,0 -> hpos advances once per two clocks, and at hpos=0 line_start stays high for 2 clocks.
REQ-042 SHALL cover: reset pulsed at hpos=300, vpos=200 -> next cycle hpos=799, vpos=524, display_on=0, hsync=1, vsync=1.
REQ-043 SHALL cover: macro defined, run 256 frames -> frame_count sequence 0..255 then returns to 0; macro undefined -> frame_count is always 0.
REQ-044 SHALL cover: SYNC_NEG=0, hpos=656 -> hsync=1, and hpos=655 -> hsync=0.
